// File: rtl/calc_pkg.sv
// Shared calculator constants: mode encodings and default display scan geometry,
// used by scan_decoder and the display driver.
package calc_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DEF_SEL_W    = 2;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_PS_W     = 16;

endpackage

// File: rtl/scan_decoder_prescaler.sv
// Scan prescaler: free-running PS_W counter that strobes step_o once every
// PRESCALE cycles; clr_i forces it back to zero and hold_i freezes it.
module scan_prescaler #(
  parameter int PRESCALE = 4,
  parameter int PS_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic hold_i,
  output logic step_o
);

  logic [PS_W-1:0] cnt_q, cnt_d;
  logic            at_end;

  assign at_end = (cnt_q == PS_W'(PRESCALE - 1));
  assign step_o = at_end && !clr_i && !hold_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = at_end ? '0 : cnt_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered 1-of-2^SEL_W decoder with direct and multiplexed-scan modes.
// Define SCAN_DECODER_ACTIVE_LOW_EN to drive out active-low (common-anode displays).
module scan_decoder
  import calc_pkg::*;
#(
  parameter int SEL_W    = DEF_SEL_W,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PS_W     = DEF_PS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  En,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      s,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap,
  output logic                  err
);

  localparam int OUT_W = 2 ** SEL_W;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_POL = '1;
`else
  localparam logic [OUT_W-1:0] OUT_POL = '0;
`endif

  mode_e            state_q;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic is_direct, scan_run, entry, ps_clr, step, cnt_last, s_ok;

  assign is_direct = (mode_e'(mode) == MODE_DIRECT);
  assign scan_run  = En && !is_direct;
  // First enabled scan cycle after direct mode restarts from channel 0.
  assign entry     = scan_run && (state_q == MODE_DIRECT);
  assign ps_clr    = (En && is_direct) || entry;
  assign cnt_last  = (cnt_q == SEL_W'(NUM_CH - 1));
  assign s_ok      = (32'(s) < 32'(NUM_CH));

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ps_clr),
    .hold_i (!En),
    .step_o (step)
  );

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    out_d  = '0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (En) begin
      if (is_direct) begin
        cnt_d = '0;
        if (s_ok) begin
          out_d[s] = 1'b1;
          idx_d    = s;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        if (entry) begin
          cnt_d = '0;
        end else if (step) begin
          cnt_d  = cnt_last ? '0 : cnt_q + SEL_W'(1);
          wrap_d = cnt_last;
        end
        out_d[cnt_d] = 1'b1;
        idx_d        = cnt_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MODE_DIRECT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= OUT_POL;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= mode_e'(mode);
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d ^ OUT_POL;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: four parameterisations share one stimulus stream and
// are checked every cycle against a time-position model plus literal expectations.
module tb_scan_decoder;

  localparam int ND = 4;
  localparam int NCH [ND] = '{4, 3, 4, 1};
  localparam int PRE [ND] = '{4, 4, 1, 3};

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [3:0] POL = 4'hF;
`else
  localparam logic [3:0] POL = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [1:0] s;

  logic [3:0] out_w  [ND];
  logic [1:0] idx_w  [ND];
  logic       wrap_w [ND];
  logic       err_w  [ND];

  int checks   = 0;
  int failures = 0;

  // Model state: t_m is the number of enabled scan cycles since scan entry.
  longint     t_m      [ND];
  logic       prev_mode;
  logic [3:0] exp_out  [ND];
  logic [1:0] exp_idx  [ND];
  logic       exp_wrap [ND];
  logic       exp_err  [ND];

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .NUM_CH(4), .PRESCALE(4), .PS_W(16)) dut0 (
    .clk(clk), .rst(rst), .En(en), .mode(mode), .s(s),
    .out(out_w[0]), .idx(idx_w[0]), .wrap(wrap_w[0]), .err(err_w[0]));
  scan_decoder #(.SEL_W(2), .NUM_CH(3), .PRESCALE(4), .PS_W(16)) dut1 (
    .clk(clk), .rst(rst), .En(en), .mode(mode), .s(s),
    .out(out_w[1]), .idx(idx_w[1]), .wrap(wrap_w[1]), .err(err_w[1]));
  scan_decoder #(.SEL_W(2), .NUM_CH(4), .PRESCALE(1), .PS_W(16)) dut2 (
    .clk(clk), .rst(rst), .En(en), .mode(mode), .s(s),
    .out(out_w[2]), .idx(idx_w[2]), .wrap(wrap_w[2]), .err(err_w[2]));
  scan_decoder #(.SEL_W(2), .NUM_CH(1), .PRESCALE(3), .PS_W(16)) dut3 (
    .clk(clk), .rst(rst), .En(en), .mode(mode), .s(s),
    .out(out_w[3]), .idx(idx_w[3]), .wrap(wrap_w[3]), .err(err_w[3]));

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    prev_mode = 1'b0;
    for (int d = 0; d < ND; d++) begin
      t_m[d]      = 0;
      exp_out[d]  = 4'h0;
      exp_idx[d]  = 2'd0;
      exp_wrap[d] = 1'b0;
      exp_err[d]  = 1'b0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      exp_wrap[d] = 1'b0;
      exp_err[d]  = 1'b0;
      if (!en) begin
        exp_out[d] = 4'h0;
      end else if (!mode) begin
        t_m[d] = 0;
        if (int'(s) < NCH[d]) begin
          exp_out[d] = 4'(1) << s;
          exp_idx[d] = s;
        end else begin
          exp_out[d] = 4'h0;
          exp_err[d] = 1'b1;
        end
      end else begin
        if (!prev_mode) t_m[d] = 0;
        else            t_m[d] = t_m[d] + 1;
        exp_idx[d]  = 2'((t_m[d] / PRE[d]) % NCH[d]);
        exp_out[d]  = 4'(1) << exp_idx[d];
        exp_wrap[d] = (t_m[d] != 0) && ((t_m[d] % (NCH[d] * PRE[d])) == 0);
      end
    end
    prev_mode = mode;
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      chk("out",    d, 32'(out_w[d]),  32'(exp_out[d] ^ POL));
      chk("idx",    d, 32'(idx_w[d]),  32'(exp_idx[d]));
      chk("wrap",   d, 32'(wrap_w[d]), 32'(exp_wrap[d]));
      chk("err",    d, 32'(err_w[d]),  32'(exp_err[d]));
      chk("onehot", d, 32'($countones(out_w[d] ^ POL) <= 1), 32'h1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    s    = 2'd0;
    model_reset();
    cycle();
    cycle();
    chk("lit_rst_out",  0, 32'(out_w[0]),  32'(POL));
    chk("lit_rst_idx",  0, 32'(idx_w[0]),  32'h0);
    chk("lit_rst_wrap", 0, 32'(wrap_w[0]), 32'h0);
    chk("lit_rst_err",  0, 32'(err_w[0]),  32'h0);
    rst = 1'b0;
    cycle();
    chk("lit_dis_out", 0, 32'(out_w[0]), 32'(POL));

    // Scan period from entry
    en   = 1'b1;
    mode = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      cycle();
      if (k == 1)  chk("lit_scan_k1",  0, 32'(out_w[0]), 32'(4'b0001 ^ POL));
      if (k == 4)  chk("lit_scan_k4",  0, 32'(out_w[0]), 32'(4'b0001 ^ POL));
      if (k == 5)  chk("lit_scan_k5",  0, 32'(out_w[0]), 32'(4'b0010 ^ POL));
      if (k == 9)  chk("lit_scan_k9",  0, 32'(out_w[0]), 32'(4'b0100 ^ POL));
      if (k == 13) chk("lit_scan_k13", 0, 32'(out_w[0]), 32'(4'b1000 ^ POL));
      if (k == 16) chk("lit_wrap_k16", 0, 32'(wrap_w[0]), 32'h0);
      if (k == 17) begin
        chk("lit_wrap_k17", 0, 32'(wrap_w[0]), 32'h1);
        chk("lit_scan_k17", 0, 32'(out_w[0]), 32'(4'b0001 ^ POL));
      end
      if (k == 33) chk("lit_wrap_k33", 0, 32'(wrap_w[0]), 32'h1);
      if (k == 3)  chk("lit_p1_idx",   2, 32'(idx_w[2]),  32'h2);
      if (k == 5)  chk("lit_p1_wrap",  2, 32'(wrap_w[2]), 32'h1);
      if (k == 3)  chk("lit_n1_wrap3", 3, 32'(wrap_w[3]), 32'h0);
      if (k == 4) begin
        chk("lit_n1_wrap4", 3, 32'(wrap_w[3]), 32'h1);
        chk("lit_n1_out",   3, 32'(out_w[3]),  32'(4'b0001 ^ POL));
      end
    end

    // Reset while idx=2, then restart with a full first period
    mode = 1'b0;
    cycle();
    mode = 1'b1;
    for (int k = 1; k <= 9; k++) cycle();
    chk("lit_pre_rst_idx", 0, 32'(idx_w[0]), 32'h2);
    async_reset();
    chk("lit_async_out", 0, 32'(out_w[0]), 32'(POL));
    chk("lit_async_idx", 0, 32'(idx_w[0]), 32'h0);
    cycle();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (k <= 4) chk("lit_rel_out", 0, 32'(out_w[0]), 32'(4'b0001 ^ POL));
      else        chk("lit_rel_out5", 0, 32'(out_w[0]), 32'(4'b0010 ^ POL));
    end

    // Enable pause in the middle of channel 1
    mode = 1'b0;
    cycle();
    mode = 1'b1;
    for (int k = 1; k <= 6; k++) cycle();
    chk("lit_pause_idx", 0, 32'(idx_w[0]), 32'h1);
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("lit_pause_out",  0, 32'(out_w[0]),  32'(POL));
      chk("lit_pause_wrap", 0, 32'(wrap_w[0]), 32'h0);
    end
    en = 1'b1;
    cycle();
    chk("lit_resume1", 0, 32'(idx_w[0]), 32'h1);
    cycle();
    chk("lit_resume2", 0, 32'(idx_w[0]), 32'h1);
    cycle();
    chk("lit_resume3", 0, 32'(idx_w[0]), 32'h2);

    // Direct sweep on the NUM_CH=3 instance
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      cycle();
      if (k == 0) chk("lit_dir_s0", 1, 32'(out_w[1]), 32'(4'b0001 ^ POL));
      if (k == 1) chk("lit_dir_s1", 1, 32'(out_w[1]), 32'(4'b0010 ^ POL));
      if (k == 2) chk("lit_dir_s2", 1, 32'(out_w[1]), 32'(4'b0100 ^ POL));
      if (k == 3) begin
        chk("lit_dir_s3",  1, 32'(out_w[1]), 32'(POL));
        chk("lit_dir_err", 1, 32'(err_w[1]), 32'h1);
        chk("lit_dir_idx", 1, 32'(idx_w[1]), 32'h2);
      end
    end

    // scan -> direct -> scan restarts at channel 0
    mode = 1'b1;
    for (int k = 1; k <= 7; k++) cycle();
    mode = 1'b0;
    s    = 2'd3;
    cycle();
    chk("lit_tog_dir", 0, 32'(out_w[0]), 32'(4'b1000 ^ POL));
    mode = 1'b1;
    cycle();
    chk("lit_tog_idx", 0, 32'(idx_w[0]), 32'h0);
    chk("lit_tog_out", 0, 32'(out_w[0]), 32'(4'b0001 ^ POL));

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        async_reset();
        cycle();
        rst = 1'b0;
      end
      en = ($urandom_range(7) != 0);
      if ($urandom_range(19) == 0) mode = ~mode;
      s = 2'($urandom_range(3));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
